// File: rtl/log_ctrl.sv
// Link event log sequencer: qualifies handshake activity into log entries, writes them
// into a circular RAM buffer, freezes after a trigger or stop, then streams oldest-first.
module log_ctrl #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned POST_TRIG = 64,
    localparam int unsigned ENTRY_W  = 4 + 2 * DATA_SIZE + TAG_SIZE,
    localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arm_in,
    input  logic                          stop_in,
    input  logic                          parity_error_in,
    input  logic                          host_data_ready_in,
    input  logic                          network_data_ready_in,
    input  logic                          network_ack_in,
    input  logic [DATA_SIZE-1:0]          host_data_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] ndt_in,
    output logic                          wr_en_out,
    output logic [AW-1:0]                 wr_addr_out,
    output logic [ENTRY_W-1:0]            wr_data_out,
    output logic                          rd_en_out,
    output logic [AW-1:0]                 rd_addr_out,
    input  logic [ENTRY_W-1:0]            rd_data_in,
    input  logic                          rd_start_in,
    output logic                          log_valid_out,
    output logic [ENTRY_W-1:0]            log_data_out,
    input  logic                          log_ready_in,
    output logic [2:0]                    state_out,
    output logic [AW:0]                   count_out,
    output logic [AW-1:0]                 trig_addr_out,
    output logic                          triggered_out
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StTrig    = 3'd2,
        StDone    = 3'd3,
        StRead    = 3'd4,
        StWait    = 3'd5,
        StPresent = 3'd6
    } state_e;

    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(MEM_DEPTH);
    localparam logic [AW:0]   POST_LAST = (AW + 1)'(POST_TRIG);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    state_e               r_state;
    state_e               w_state_d;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [AW:0]          r_post;
    logic [AW:0]          r_remaining;
    logic [AW-1:0]        r_trig_addr;
    logic                 r_triggered;
    logic                 r_wr_en;
    logic [AW-1:0]        r_wr_addr;
    logic [ENTRY_W-1:0]   r_wr_data;
    logic                 r_log_valid;
    logic [ENTRY_W-1:0]   r_log_data;

    logic w_qual;
    logic w_write;
    logic w_trig;
    logic w_fire;

    assign w_qual = parity_error_in | host_data_ready_in | network_data_ready_in | network_ack_in;

    always_comb begin
        w_state_d = r_state;
        w_write   = 1'b0;
        w_trig    = 1'b0;
        w_fire    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (arm_in) w_state_d = StArmed;
            end
            StArmed: begin
                // stop wins over a simultaneous trigger: nothing is written
                if (stop_in) begin
                    w_state_d = StDone;
                end else if (w_qual) begin
                    w_write = 1'b1;
                    if (parity_error_in) begin
                        w_trig = 1'b1;
                        if (POST_TRIG == 0) begin
                            w_fire    = 1'b1;
                            w_state_d = StDone;
                        end else begin
                            w_state_d = StTrig;
                        end
                    end
                end
            end
            StTrig: begin
                if (stop_in) begin
                    w_state_d = StDone;
                end else if (w_qual) begin
                    w_write = 1'b1;
                    if ((r_post + CNT_ONE) == POST_LAST) begin
                        w_fire    = 1'b1;
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (rd_start_in) w_state_d = (r_count != '0) ? StRead : StIdle;
            end
            StRead:  w_state_d = StWait;
            StWait:  w_state_d = StPresent;
            StPresent: begin
                if (log_ready_in) w_state_d = (r_remaining == CNT_ONE) ? StIdle : StRead;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post      <= '0;
            r_remaining <= '0;
            r_trig_addr <= '0;
            r_triggered <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_log_valid <= 1'b0;
            r_log_data  <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= {parity_error_in, host_data_ready_in, network_data_ready_in,
                              network_ack_in, host_data_in, ndt_in};
                r_wr_ptr  <= r_wr_ptr + PTR_ONE;
                if (r_count != DEPTH_W) r_count <= r_count + CNT_ONE;
                if (r_state == StTrig) r_post <= r_post + CNT_ONE;
            end
            if (w_trig) r_trig_addr <= r_wr_ptr;
            if (w_fire) r_triggered <= 1'b1;

            if (r_state == StIdle && arm_in) begin
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_post      <= '0;
                r_triggered <= 1'b0;
            end

            // A full buffer has wrapped, so the oldest entry sits at the write pointer
            if (r_state == StDone && rd_start_in && r_count != '0) begin
                r_rd_ptr    <= (r_count == DEPTH_W) ? r_wr_ptr : '0;
                r_remaining <= r_count;
            end

            if (r_state == StWait) begin
                r_log_data  <= rd_data_in;
                r_log_valid <= 1'b1;
            end

            if (r_state == StPresent && log_ready_in) begin
                r_log_valid <= 1'b0;
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                r_remaining <= r_remaining - CNT_ONE;
                if (r_remaining == CNT_ONE) r_count <= '0;
            end
        end
    end

    assign wr_en_out     = r_wr_en;
    assign wr_addr_out   = r_wr_addr;
    assign wr_data_out   = r_wr_data;
    assign rd_en_out     = (r_state == StRead);
    assign rd_addr_out   = r_rd_ptr;
    assign log_valid_out = r_log_valid;
    assign log_data_out  = r_log_data;
    assign state_out     = r_state;
    assign count_out     = r_count;
    assign trig_addr_out = r_trig_addr;
    assign triggered_out = r_triggered;

endmodule

// File: doc/log_ctrl.md
# log_ctrl

Capture and readout sequencer for the link event log. It qualifies host/network handshake activity into 76-bit log entries and writes them into an external single-port-write / registered-read log RAM as a circular buffer. It freezes the buffer a programmable number of entries after a parity-error trigger, then streams the buffer oldest-first to a debug consumer over a valid/ready interface. It sits between the host/network interface signals and the log RAM, replacing free-running capture.

## Interface
- DATA_SIZE, 32, host data width
- TAG_SIZE, 8, network tag width; ndt_in is DATA_SIZE+TAG_SIZE bits
- MEM_DEPTH, 256, log RAM entries (power of two, ≥4)
- POST_TRIG, 64, entries written after the trigger entry (0..MEM_DEPTH-1)
- Derived: ENTRY_W = 4+2*DATA_SIZE+TAG_SIZE (76), AW = $clog2(MEM_DEPTH)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- arm_in  in  1  start capture (IDLE only)
- stop_in  in  1  manual freeze (ARMED/TRIGGERED)
- parity_error_in, host_data_ready_in, network_data_ready_in, network_ack_in  in  1 each  monitored flags
- host_data_in  in  DATA_SIZE  monitored host data
- ndt_in  in  DATA_SIZE+TAG_SIZE  monitored network data+tag
- wr_en_out  out  1  RAM write strobe
- wr_addr_out  out  AW  RAM write address
- wr_data_out  out  ENTRY_W  {parity, host_rdy, net_rdy, ack, host_data, ndt}
- rd_en_out  out  1  RAM read strobe; data returns next cycle
- rd_addr_out  out  AW  RAM read address
- rd_data_in  in  ENTRY_W  RAM read data
- rd_start_in  in  1  begin readout (DONE only)
- log_valid_out  out  1  readout entry valid
- log_data_out  out  ENTRY_W  readout entry
- log_ready_in  in  1  consumer accept
- state_out  out  3  IDLE=0, ARMED=1, TRIGGERED=2, DONE=3, READ=4, WAIT=5, PRESENT=6
- count_out  out  AW+1  valid entries stored, saturates at MEM_DEPTH
- trig_addr_out  out  AW  address of the trigger entry
- triggered_out  out  1  DONE reached via trigger (not stop)

## Operation
- Qualified sample: any of the four flags high. Only qualified samples are written.
- IDLE: no writes. arm_in → ARMED; wr_ptr, count, post counter, triggered_out cleared.
- ARMED: each qualified sample written at wr_ptr; wr_ptr += 1 mod MEM_DEPTH; count += 1 saturating. A qualified sample with parity_error_in=1 is the trigger entry: written, trig_addr_out ← its address, → TRIGGERED (or → DONE directly if POST_TRIG=0, triggered_out=1).
- TRIGGERED: qualified samples written as in ARMED (further parity errors are not retriggers). After POST_TRIG more entries → DONE, triggered_out=1.
- stop_in in ARMED/TRIGGERED: → DONE; that cycle's sample not written; triggered_out unchanged. stop_in has priority over trigger in the same cycle (no write, trig_addr_out unchanged).
- DONE: holds buffer. rd_start_in → READ if count>0, else → IDLE. arm_in ignored.
- Readout order: if count==MEM_DEPTH, start at wr_ptr; else start at 0. Emit count entries.
- READ: rd_en_out=1 at rd_ptr → WAIT. WAIT: latch rd_data_in into log_data_out, log_valid_out=1 → PRESENT. PRESENT: hold until log_ready_in; on accept rd_ptr += 1 mod MEM_DEPTH, remaining −= 1; → READ, or → IDLE after the last entry (count cleared).
- arm_in, stop_in, rd_start_in outside their states: ignored.

## Timing
- Reset (asynchronous): state IDLE; every output 0; pointers and counters 0.
- Write path registered: sample at edge N appears on wr_en_out/wr_addr_out/wr_data_out during cycle N+1. wr_en_out is a one-cycle pulse per entry; back-to-back qualified cycles yield consecutive writes.
- State transition occurs on the same edge that captures the causing sample/command.
- Readout: 3 cycles per entry minimum (READ, WAIT, PRESENT with ready high); log_valid_out/log_data_out stable while ready low.
- Reset asserted mid-capture or mid-readout: immediate return to IDLE; partial readout abandoned, log_valid_out drops asynchronously.

## Test plan
- Arm, drive 5 qualified samples (host_data_in=1..5), stop → wr_addr 0..4, count_out=5; readout yields entries 1..5 in order, then IDLE.
- Arm, 300 qualified samples without trigger (MEM_DEPTH=256), stop → count_out=256; readout starts at wr_ptr=44, first entry is sample 45, last is sample 300.
- Arm, parity error on 10th sample, POST_TRIG=64 → trig_addr_out=9, DONE after entry 74 written, triggered_out=1; later samples not written.
- stop_in and parity-error sample in same ARMED cycle → no write, trig_addr_out unchanged, triggered_out=0.
- Readout with log_ready_in held low 7 cycles → log_data_out stable, no rd_en_out pulse until accept.
- Reset low during PRESENT → state_out=0, log_valid_out=0, count_out=0 immediately; rd_start_in afterward ignored.
